// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder/subtractor: FSM encoding and
// the sizing helper for the step counter.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bits needed to hold values 0..steps-1, never less than one.
  function automatic int cnt_width(input int steps);
    int w;
    w = 1;
    while ((1 << w) < steps) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder composed of two half adders and an OR of their carries.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic hs1_s;
  logic hc1_s;
  logic hc2_s;

  assign hs1_s = a ^ b;
  assign hc1_s = a & b;
  assign s     = hs1_s ^ ci;
  assign hc2_s = hs1_s & ci;
  assign co    = hc1_s | hc2_s;

endmodule

// File: rtl/serial_add_sub.sv
// Multi-cycle adder/subtractor: BITS_PER_CYCLE bits per clock, LSB first,
// with start/busy/done handshake, carry-out and signed overflow.
module serial_add_sub
  import adder_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = cnt_width(STEPS);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]        opa_q, opa_d;
  logic [WIDTH-1:0]        opb_q, opb_d;
  logic                    carry_q, carry_d;
  logic [WIDTH-1:0]        sum_q, sum_d;
  logic                    cout_q, cout_d;
  logic                    ovf_q, ovf_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [BITS_PER_CYCLE:0]   chain_s;
  logic [BITS_PER_CYCLE-1:0] slice_s;
  logic [WIDTH-1:0]          shift_s;

  assign chain_s[0] = carry_q;

  // Ripple chain of full adders over the current low slice of the operands.
  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_fa
    fa_cell u_fa (
      .a  (opa_q[g]),
      .b  (opb_q[g]),
      .ci (chain_s[g]),
      .s  (slice_s[g]),
      .co (chain_s[g+1])
    );
  end

  // New slice enters at the top so the full result lands aligned after STEPS shifts.
  if (BITS_PER_CYCLE == WIDTH) begin : g_shift_full
    assign shift_s = slice_s;
  end else begin : g_shift_part
    assign shift_s = {slice_s, sum_q[WIDTH-1:BITS_PER_CYCLE]};
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = CW'(STEPS - 1);
          busy_d  = 1'b1;
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        opa_d   = opa_q >> BITS_PER_CYCLE;
        opb_d   = opb_q >> BITS_PER_CYCLE;
        carry_d = chain_s[BITS_PER_CYCLE];
        sum_d   = shift_s;
        if (cnt_q == '0) begin
          cout_d  = chain_s[BITS_PER_CYCLE];
          ovf_d   = chain_s[BITS_PER_CYCLE] ^ chain_s[BITS_PER_CYCLE-1];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and randomised checks of serial_add_sub at one and four bits per cycle.
module tb_serial_add_sub;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start1 = 1'b0;
  logic       start4 = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;

  logic       busy1, done1, cout1, ovf1;
  logic [7:0] sum1;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] sum4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub), .a(a), .b(b),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  serial_add_sub #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub), .a(a), .b(b),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: returns {cout, ovf, sum}.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic [7:0] yy;
    logic [8:0] r;
    yy = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, yy} + {8'd0, s};
    return {r[8], (x[7] == yy[7]) && (r[7] != x[7]), r[7:0]};
  endfunction

  // Issues one operation at the current sample point and checks latency and result.
  task automatic do_op(input logic sel4, input logic [7:0] oa, input logic [7:0] ob,
                       input logic os, input logic [7:0] es, input logic ec,
                       input logic eo, input string tag);
    int   cyc;
    int   busy_n;
    int   steps;
    logic d;
    logic bz;
    steps = sel4 ? 2 : 8;
    a = oa;
    b = ob;
    sub = os;
    if (sel4) start4 = 1'b1;
    else start1 = 1'b1;
    tick();
    start1 = 1'b0;
    start4 = 1'b0;
    a = ~oa;
    b = ob ^ 8'h5A;
    sub = ~os;
    cyc = 0;
    busy_n = 0;
    d = 1'b0;
    while (!d && cyc < 40) begin
      d  = sel4 ? done4 : done1;
      bz = sel4 ? busy4 : busy1;
      if (!d) begin
        if (bz) busy_n++;
        tick();
        cyc++;
      end
    end
    chk({tag, "_done"}, 32'(d), 32'd1);
    chk({tag, "_lat"}, 32'(cyc), 32'(steps));
    chk({tag, "_busycyc"}, 32'(busy_n), 32'(steps));
    chk({tag, "_busy_at_done"}, 32'(sel4 ? busy4 : busy1), 32'd0);
    chk({tag, "_sum"}, 32'(sel4 ? sum4 : sum1), 32'(es));
    chk({tag, "_cout"}, 32'(sel4 ? cout4 : cout1), 32'(ec));
    chk({tag, "_ovf"}, 32'(sel4 ? ovf4 : ovf1), 32'(eo));
  endtask

  initial begin
    int         pulses;
    logic [7:0] cap;
    logic [7:0] ra, rb;
    logic       rs;
    logic [9:0] m;

    // Reset state
    tick();
    tick();
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    chk("rst_sum1", 32'(sum1), 32'd0);
    chk("rst_cout1", 32'(cout1), 32'd0);
    chk("rst_ovf1", 32'(ovf1), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_sum4", 32'(sum4), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: add with signed overflow, then done must drop and result hold
    do_op(1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "t1");
    tick();
    chk("t1_done_pulse", 32'(done1), 32'd0);
    chk("t1_sum_hold", 32'(sum1), 32'h96);
    tick();

    // 2: subtract with borrow
    do_op(1'b0, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, "t2");

    // 3: back-to-back, second start issued in the done cycle
    do_op(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "t3a");
    do_op(1'b0, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "t3b");
    tick();

    // 4: start while busy is ignored
    a = 8'h01; b = 8'h01; sub = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    a = 8'hFF; b = 8'hFF; sub = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    pulses = 0;
    cap = 8'h00;
    for (int i = 0; i < 14; i++) begin
      if (done1) begin
        pulses++;
        cap = sum1;
      end
      tick();
    end
    chk("t4_pulses", 32'(pulses), 32'd1);
    chk("t4_sum", 32'(cap), 32'h02);
    chk("t4_busy", 32'(busy1), 32'd0);

    // 5: reset mid-operation clears everything immediately
    a = 8'h5A; b = 8'h3C; sub = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy1), 32'd0);
    chk("t5_done", 32'(done1), 32'd0);
    chk("t5_sum", 32'(sum1), 32'd0);
    chk("t5_cout", 32'(cout1), 32'd0);
    chk("t5_ovf", 32'(ovf1), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_op(1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "t5_after");

    // 6: four bits per cycle, then random ops on both instances
    tick();
    do_op(1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "t6");
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      m  = model(ra, rb, rs);
      do_op(1'b0, ra, rb, rs, m[7:0], m[9], m[8], "rnd1");
    end
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      m  = model(ra, rb, rs);
      do_op(1'b1, ra, rb, rs, m[7:0], m[9], m[8], "rnd4");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
